pdp11_bus_arb: RTL and testbench
================================

Name: pdp11_bus_arb

Overview:
- Parametrised successor of the single-DMA PDP-11 bus arbiter/decoder.
- Arbitrates between the CPU and N DMA channels for the RAM port, using round-robin among channels and a configurable burst length with early release.
- Decodes CPU cycles into RAM or I/O-page accesses, raises bus error, and muxes read data.
- Sits between the CPU bus, the RAM controller and the iopage block.

Parameters:
- AW, 22, CPU physical address width (16, 18 or 22); I/O page is the top 8 KB.
- DMA_AW, 18, DMA channel address width, zero-extended to AW.
- NCH, 2, number of DMA channels (1..8).
- BURST, 4, maximum consecutive DMA cycles per grant (1..15).
- RAM_TOP, 22'o760000, first non-present RAM address; CPU RAM access at or above it is a bus error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_addr  in  AW  CPU physical address
- cpu_data_in  in  16  CPU write data
- cpu_rd, cpu_wr, cpu_byte_op  in  1 each  CPU cycle strobes
- cpu_arbitrate  in  1  CPU permits a DMA grant this cycle
- cpu_ack  out  1  CPU owns the RAM port
- cpu_error  out  1  bus error for the current CPU cycle
- cpu_data_out  out  16  CPU read data
- dma_req  in  NCH  per-channel request
- dma_addr  in  NCH*DMA_AW  channel addresses; channel i at bits [i*DMA_AW +: DMA_AW]
- dma_rd, dma_wr  in  NCH each  channel strobes
- dma_wdata  in  NCH*16  channel write data
- dma_ack  out  NCH  one-hot grant
- dma_rdata  out  16  RAM read data, shared by all channels
- ram_addr  out  AW  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data
- ram_rd, ram_wr, ram_byte_op  out  1 each  RAM strobes
- io_rd, io_wr  out  1 each  I/O-page strobes
- io_rdata  in  16  iopage read data
- io_no_decode  in  1  iopage reports unmapped address
- grant_chan  out  3  index of the granted channel (0 when idle)

Behaviour:
- Decode:
  - iopage = cpu_addr[AW-1:13] all ones; ram_acc = ~iopage.
  - io_rd = cpu_rd & iopage; io_wr = cpu_wr & iopage. Both are independent of grant state, because the I/O page never uses the RAM port.
  - cpu_data_out = ram_acc ? ram_rdata : io_rdata.
  - cpu_error = (iopage & io_no_decode) | (ram_acc & (cpu_rd|cpu_wr) & cpu_addr >= RAM_TOP). Combinational, same cycle.
- Arbiter FSM, all registered:
  - State: IDLE or BURST; owner register ch; count register cnt (4 bits); round-robin pointer rr.
  - IDLE -> BURST when cpu_arbitrate & |dma_req. ch = first requesting channel at or after rr, wrapping modulo NCH. cnt = 1.
  - BURST: if dma_req[ch] & cnt < BURST, then cnt++. Else go to IDLE and set rr = (ch+1) mod NCH.
  - Early release: when dma_req[ch] drops, the FSM returns to IDLE at the next edge.
  - The FSM always returns to IDLE between bursts, so the CPU gets at least one owned cycle. A new grant also needs cpu_arbitrate again.
  - Requests from other channels never pre-empt the current burst.
- Latency: a request and cpu_arbitrate sampled at edge k give dma_ack visible after edge k. A full burst gives exactly BURST ack cycles.
- Outputs:
  - cpu_ack = (state==IDLE). dma_ack[i] = (state==BURST & ch==i). grant_chan = ch in BURST, else 0.
- RAM mux:
  - CPU owns the port: ram_addr = cpu_addr, ram_wdata = cpu_data_in, ram_rd = cpu_rd & ram_acc, ram_wr = cpu_wr & ram_acc, ram_byte_op = cpu_byte_op.
  - DMA owns the port: ram_addr = zero-extended dma_addr[ch], ram_wdata = dma_wdata[ch], ram_rd = dma_rd[ch], ram_wr = dma_wr[ch], ram_byte_op = 0.
  - dma_rdata = ram_rdata at all times.
  - CPU strobes are ignored for RAM while cpu_ack = 0. The CPU is required to stall on ~cpu_ack.
- Reset:
  - state = IDLE, ch = 0, cnt = 0, rr = 0. Hence cpu_ack = 1, dma_ack = 0, grant_chan = 0.
  - Reset mid-burst drops dma_ack at that edge.
- Simultaneous events:
  - All channels requesting: channels are served strictly in rotation.
  - A channel requesting while not granted is held off, with no lost state; requests are levels.
  - NCH = 1 degenerates to the legacy behaviour.

Test Plan:
- Burst: NCH=2, BURST=4. dma_req=01 held, cpu_arbitrate=1 -> dma_ack=01 for exactly 4 cycles, then cpu_ack=1 for ≥1 cycle, then re-grant.
- Early release: dma_req[0] deasserted after 2 granted cycles -> dma_ack=0 and cpu_ack=1 on the next edge; rr=1.
- Round-robin: dma_req=11 held -> grants alternate ch0 (4 cycles), CPU, ch1 (4 cycles), CPU, ch0 (4 cycles); grant_chan follows 0,1,0.
- Gating: dma_req=01, cpu_arbitrate=0 for 10 cycles -> no dma_ack. Raise cpu_arbitrate -> ack on the next cycle.
- Decode/error: CPU read at 22'o770000 (RAM above RAM_TOP) -> cpu_error=1, ram_rd=1. Read at 22'o17777560 with io_no_decode=0 -> io_rd=1, ram_rd=0, cpu_data_out=io_rdata. Set io_no_decode=1 -> cpu_error=1.
- Reset mid-burst: assert reset in the 2nd granted cycle -> dma_ack=0, cpu_ack=1, grant_chan=0 after the edge. After release, the ch0 request is re-granted starting from rr=0.

Source files
------------

// File: rtl/pdp11_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : pdp11_bus_arb
// Brief    : CPU / N-channel DMA arbiter for the RAM port, with CPU address decode.
// Revision : 1.0
// ============================================================================
module pdp11_bus_arb #(
    parameter int             AW      = 22,
    parameter int             DMA_AW  = 18,
    parameter int             NCH     = 2,
    parameter int             BURST   = 4,
    parameter logic [AW-1:0]  RAM_TOP = AW'(22'o760000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         cpu_addr_i,
    input  logic [15:0]           cpu_data_in_i,
    input  logic                  cpu_rd_i,
    input  logic                  cpu_wr_i,
    input  logic                  cpu_byte_op_i,
    input  logic                  cpu_arbitrate_i,
    output logic                  cpu_ack_o,
    output logic                  cpu_error_o,
    output logic [15:0]           cpu_data_out_o,
    input  logic [NCH-1:0]        dma_req_i,
    input  logic [NCH*DMA_AW-1:0] dma_addr_i,
    input  logic [NCH-1:0]        dma_rd_i,
    input  logic [NCH-1:0]        dma_wr_i,
    input  logic [NCH*16-1:0]     dma_wdata_i,
    output logic [NCH-1:0]        dma_ack_o,
    output logic [15:0]           dma_rdata_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [15:0]           ram_wdata_o,
    input  logic [15:0]           ram_rdata_i,
    output logic                  ram_rd_o,
    output logic                  ram_wr_o,
    output logic                  ram_byte_op_o,
    output logic                  io_rd_o,
    output logic                  io_wr_o,
    input  logic [15:0]           io_rdata_i,
    input  logic                  io_no_decode_i,
    output logic [2:0]            grant_chan_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           state_q;
    logic [2:0]       ch_q;
    logic [3:0]       cnt_q;
    logic [2:0]       rr_q;
    logic             cpu_ack_q;
    logic [NCH-1:0]   dma_ack_q;
    logic [2:0]       grant_q;

    logic [7:0]       req_pad;
    logic [2:0]       pick_ch_d;
    logic [NCH-1:0]   pick_oh_d;
    logic [2:0]       rr_d;
    logic [3:0]       scan_idx;

    logic [DMA_AW-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic              sel_rd;
    logic              sel_wr;

    logic iopage;
    logic ram_acc;
    logic dma_own;

    assign req_pad = 8'(dma_req_i);

    // Scan downward so the first requester at or after rr_q wins.
    always_comb begin
        pick_ch_d = '0;
        scan_idx  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_q} + 4'(k);
            if (scan_idx >= 4'(NCH)) begin
                scan_idx = scan_idx - 4'(NCH);
            end
            if (req_pad[scan_idx[2:0]]) begin
                pick_ch_d = scan_idx[2:0];
            end
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_pick_oh
            assign pick_oh_d[i] = (pick_ch_d == 3'(i));
        end
    endgenerate

    assign rr_d = (ch_q == 3'(NCH - 1)) ? 3'd0 : ch_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            cpu_ack_q <= 1'b1;
            dma_ack_q <= '0;
            grant_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_arbitrate_i && (|dma_req_i)) begin
                        state_q   <= S_BURST;
                        ch_q      <= pick_ch_d;
                        cnt_q     <= 4'd1;
                        cpu_ack_q <= 1'b0;
                        dma_ack_q <= pick_oh_d;
                        grant_q   <= pick_ch_d;
                    end
                end
                S_BURST: begin
                    if (req_pad[ch_q] && (cnt_q < 4'(BURST))) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        // Always drop back to IDLE so the CPU gets a cycle between bursts.
                        state_q   <= S_IDLE;
                        rr_q      <= rr_d;
                        cpu_ack_q <= 1'b1;
                        dma_ack_q <= '0;
                        grant_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 3'(i)) begin
                sel_addr  = dma_addr_i[i*DMA_AW +: DMA_AW];
                sel_wdata = dma_wdata_i[i*16 +: 16];
                sel_rd    = dma_rd_i[i];
                sel_wr    = dma_wr_i[i];
            end
        end
    end

    assign iopage  = &cpu_addr_i[AW-1:13];
    assign ram_acc = ~iopage;
    assign dma_own = ~cpu_ack_q;

    assign io_rd_o        = cpu_rd_i & iopage;
    assign io_wr_o        = cpu_wr_i & iopage;
    assign cpu_data_out_o = ram_acc ? ram_rdata_i : io_rdata_i;
    assign cpu_error_o    = (iopage & io_no_decode_i)
                          | (ram_acc & (cpu_rd_i | cpu_wr_i) & (cpu_addr_i >= RAM_TOP));

    assign ram_addr_o    = dma_own ? AW'(sel_addr) : cpu_addr_i;
    assign ram_wdata_o   = dma_own ? sel_wdata     : cpu_data_in_i;
    assign ram_rd_o      = dma_own ? sel_rd        : (cpu_rd_i & ram_acc);
    assign ram_wr_o      = dma_own ? sel_wr        : (cpu_wr_i & ram_acc);
    assign ram_byte_op_o = dma_own ? 1'b0          : cpu_byte_op_i;
    assign dma_rdata_o   = ram_rdata_i;

    assign cpu_ack_o    = cpu_ack_q;
    assign dma_ack_o    = dma_ack_q;
    assign grant_chan_o = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_pdp11_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp11_bus_arb
// Brief    : Scoreboard bench for pdp11_bus_arb (NCH=2, BURST=4 defaults).
// Revision : 1.0
// ============================================================================
module tb_pdp11_bus_arb;

    localparam int AW     = 22;
    localparam int DMA_AW = 18;
    localparam int NCH    = 2;

    localparam logic [DMA_AW-1:0] C_A0 = 18'o123456;
    localparam logic [DMA_AW-1:0] C_A1 = 18'o654321;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     cpu_addr;
    logic [15:0]       cpu_data_in;
    logic              cpu_rd, cpu_wr, cpu_byte_op, cpu_arbitrate;
    logic              cpu_ack, cpu_error;
    logic [15:0]       cpu_data_out;
    logic [NCH-1:0]    dma_req, dma_rd, dma_wr, dma_ack;
    logic [NCH*DMA_AW-1:0] dma_addr;
    logic [NCH*16-1:0] dma_wdata;
    logic [15:0]       dma_rdata;
    logic [AW-1:0]     ram_addr;
    logic [15:0]       ram_wdata, ram_rdata;
    logic              ram_rd, ram_wr, ram_byte_op;
    logic              io_rd, io_wr, io_no_decode;
    logic [15:0]       io_rdata;
    logic [2:0]        grant_chan;

    always #5 clk = ~clk;

    pdp11_bus_arb dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_in_i  (cpu_data_in),
        .cpu_rd_i       (cpu_rd),
        .cpu_wr_i       (cpu_wr),
        .cpu_byte_op_i  (cpu_byte_op),
        .cpu_arbitrate_i(cpu_arbitrate),
        .cpu_ack_o      (cpu_ack),
        .cpu_error_o    (cpu_error),
        .cpu_data_out_o (cpu_data_out),
        .dma_req_i      (dma_req),
        .dma_addr_i     (dma_addr),
        .dma_rd_i       (dma_rd),
        .dma_wr_i       (dma_wr),
        .dma_wdata_i    (dma_wdata),
        .dma_ack_o      (dma_ack),
        .dma_rdata_o    (dma_rdata),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata),
        .ram_rd_o       (ram_rd),
        .ram_wr_o       (ram_wr),
        .ram_byte_op_o  (ram_byte_op),
        .io_rd_o        (io_rd),
        .io_wr_o        (io_wr),
        .io_rdata_i     (io_rdata),
        .io_no_decode_i (io_no_decode),
        .grant_chan_o   (grant_chan)
    );

    typedef struct packed {
        logic [127:0]   nm;
        logic           chk_arb;
        logic           ack;
        logic [NCH-1:0] dack;
        logic [2:0]     gr;
        logic           chk_ram;
        logic [AW-1:0]  raddr;
        logic [15:0]    rwd;
        logic           rrd;
        logic           rwr;
        logic           rbyte;
        logic           chk_dec;
        logic           err;
        logic           iord;
        logic           iowr;
        logic [15:0]    cdo;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Each entry describes what must be visible at the following falling edge.
    task automatic cyc(input logic [127:0] nm, input logic [NCH-1:0] req, input logic arb,
                       input logic ack, input logic [NCH-1:0] dack, input logic [2:0] gr);
        exp_t e;
        e = '0;
        dma_req       = req;
        cpu_arbitrate = arb;
        e.nm = nm; e.chk_arb = 1'b1; e.ack = ack; e.dack = dack; e.gr = gr;
        if (dack == 2'b01) begin
            e.chk_ram = 1'b1; e.raddr = {4'b0, C_A0}; e.rwd = 16'h1111;
            e.rrd = 1'b1; e.rwr = 1'b0; e.rbyte = 1'b0;
        end else if (dack == 2'b10) begin
            e.chk_ram = 1'b1; e.raddr = {4'b0, C_A1}; e.rwd = 16'h2222;
            e.rrd = 1'b0; e.rwr = 1'b1; e.rbyte = 1'b0;
        end
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic dec(input logic [127:0] nm, input logic [AW-1:0] addr, input logic rd,
                       input logic wr, input logic nodec, input logic err, input logic rrd,
                       input logic rwr, input logic iord, input logic iowr, input logic [15:0] cdo);
        exp_t e;
        e = '0;
        dma_req = '0; cpu_arbitrate = 1'b0;
        cpu_addr = addr; cpu_rd = rd; cpu_wr = wr; cpu_byte_op = 1'b0;
        cpu_data_in = 16'hC3C3; io_no_decode = nodec;
        e.nm = nm;
        e.chk_arb = 1'b1; e.ack = 1'b1; e.dack = '0; e.gr = 3'd0;
        e.chk_ram = 1'b1; e.raddr = addr; e.rwd = 16'hC3C3; e.rrd = rrd; e.rwr = rwr; e.rbyte = 1'b0;
        e.chk_dec = 1'b1; e.err = err; e.iord = iord; e.iowr = iowr; e.cdo = cdo;
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            if (m.chk_arb) begin
                n_chk++;
                if (cpu_ack !== m.ack || dma_ack !== m.dack || grant_chan !== m.gr)
                    $display("FAIL %0s arb: got ack=%b dma_ack=%b grant=%0d, want ack=%b dma_ack=%b grant=%0d",
                             m.nm, cpu_ack, dma_ack, grant_chan, m.ack, m.dack, m.gr);
                else n_pass++;
            end
            if (m.chk_ram) begin
                n_chk++;
                if (ram_addr !== m.raddr || ram_wdata !== m.rwd || ram_rd !== m.rrd ||
                    ram_wr !== m.rwr || ram_byte_op !== m.rbyte)
                    $display("FAIL %0s ram: got addr=%o wd=%h rd=%b wr=%b byte=%b, want addr=%o wd=%h rd=%b wr=%b byte=%b",
                             m.nm, ram_addr, ram_wdata, ram_rd, ram_wr, ram_byte_op,
                             m.raddr, m.rwd, m.rrd, m.rwr, m.rbyte);
                else n_pass++;
            end
            if (m.chk_dec) begin
                n_chk++;
                if (cpu_error !== m.err || io_rd !== m.iord || io_wr !== m.iowr ||
                    cpu_data_out !== m.cdo || dma_rdata !== 16'hA5A5)
                    $display("FAIL %0s dec: got err=%b io_rd=%b io_wr=%b cdo=%h dma_rdata=%h, want err=%b io_rd=%b io_wr=%b cdo=%h dma_rdata=a5a5",
                             m.nm, cpu_error, io_rd, io_wr, cpu_data_out, dma_rdata,
                             m.err, m.iord, m.iowr, m.cdo);
                else n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending", q.size());
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cpu_addr = 22'o001000; cpu_data_in = 16'h7777;
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_byte_op = 1'b1; cpu_arbitrate = 1'b0;
        dma_req = '0; dma_addr = {C_A1, C_A0}; dma_rd = 2'b01; dma_wr = 2'b10;
        dma_wdata = {16'h2222, 16'h1111}; ram_rdata = 16'hA5A5; io_rdata = 16'h5A5A;
        io_no_decode = 1'b0;
        @(negedge clk); #1;

        cyc("reset0", 2'b01, 1'b1, 1'b1, 2'b00, 3'd0);
        cyc("reset1", 2'b01, 1'b1, 1'b1, 2'b00, 3'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) cyc("burst", 2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("burst_cpu",   2'b01, 1'b1, 1'b1, 2'b00, 3'd0);
        cyc("burst_regr",  2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("burst_drop",  2'b00, 1'b1, 1'b1, 2'b00, 3'd0);

        cyc("early1",      2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("early2",      2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("early_rel",   2'b00, 1'b1, 1'b1, 2'b00, 3'd0);

        for (int i = 0; i < 4; i++) cyc("rr_ch1a", 2'b11, 1'b1, 1'b0, 2'b10, 3'd1);
        cyc("rr_cpu0",     2'b11, 1'b1, 1'b1, 2'b00, 3'd0);
        for (int i = 0; i < 4; i++) cyc("rr_ch0", 2'b11, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("rr_cpu1",     2'b11, 1'b1, 1'b1, 2'b00, 3'd0);
        cyc("rr_ch1b",     2'b11, 1'b1, 1'b0, 2'b10, 3'd1);
        cyc("rr_end",      2'b00, 1'b1, 1'b1, 2'b00, 3'd0);

        for (int i = 0; i < 10; i++) cyc("gate_off", 2'b01, 1'b0, 1'b1, 2'b00, 3'd0);
        cyc("gate_on",     2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("gate_end",    2'b00, 1'b1, 1'b1, 2'b00, 3'd0);

        cyc("rst_g1",      2'b01, 1'b1, 1'b0, 2'b01, 3'd0);
        reset = 1'b1;
        cyc("rst_mid",     2'b01, 1'b1, 1'b1, 2'b00, 3'd0);
        reset = 1'b0;
        cyc("rst_regr",    2'b11, 1'b1, 1'b0, 2'b01, 3'd0);
        cyc("rst_end",     2'b00, 1'b1, 1'b1, 2'b00, 3'd0);

        dec("d_top_rd",   22'o770000,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5);
        dec("d_io_rd",    22'o17777560, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A);
        dec("d_io_nodec", 22'o17777560, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A);
        dec("d_ram_rd",   22'o001000,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5);
        dec("d_edge_wr",  22'o760000,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5A5);
        dec("d_below_wr", 22'o757776,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5A5);
        dec("d_io_wr",    22'o17777776, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        dec("d_nostrobe", 22'o770000,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5);

        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
